// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: control-unit handshake plus the instruction memory read port.
// The fetch unit takes the master modport; the surrounding CPU/memory take the slave modport.
interface instr_fetch_unit_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16
);
   logic [ADDR_W-1:0] pc_addr;
   logic              fetch_req;
   logic              ir_consume;
   logic              flush;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_data;
   logic [DATA_W-1:0] ir_out;
   logic              ir_valid;
   logic              pc_inc;
   logic              busy;
   logic              fetch_err;

   modport master (
      input  pc_addr, fetch_req, ir_consume, flush, mem_ack, mem_data,
      output mem_addr, mem_rd, ir_out, ir_valid, pc_inc, busy, fetch_err
   );

   modport slave (
      output pc_addr, fetch_req, ir_consume, flush, mem_ack, mem_data,
      input  mem_addr, mem_rd, ir_out, ir_valid, pc_inc, busy, fetch_err
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: handshaked instruction-memory read into IR, then a one-cycle PC increment pulse.
// Define FETCH_TIMEOUT_EN to add a WAIT-state timeout with a sticky fetch_err flag.
module instr_fetch_unit #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16
`ifdef FETCH_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT = 15
`endif
) (
   input logic                clk,
   input logic                rst,
   instr_fetch_unit_if.master bus
);
   typedef enum logic [1:0] {StIdle, StWait, StFlush} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              rd_q, rd_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic              irv_q, irv_d;
   logic              inc_q, inc_d;
   logic              timeout;

`ifdef FETCH_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT + 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            err_q, err_d;

   assign timeout = (cnt_q == CntW'(TIMEOUT - 1));

   // Counter idles at zero outside WAIT, so every entry to WAIT starts a fresh count.
   always_comb begin
      cnt_d = '0;
      err_d = err_q;
      if (state_q == StWait && !bus.mem_ack) begin
         cnt_d = cnt_q + 1'b1;
      end
      if (state_q == StWait && !bus.flush && !bus.mem_ack && timeout) begin
         err_d = 1'b1;
      end
      if (bus.flush) begin
         err_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign bus.fetch_err = err_q;
`else
   assign timeout       = 1'b0;
   assign bus.fetch_err = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rd_d    = rd_q;
      ir_d    = ir_q;
      irv_d   = irv_q & ~bus.ir_consume;
      inc_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.fetch_req && (!irv_q || bus.ir_consume) && !bus.flush) begin
               addr_d  = bus.pc_addr;
               rd_d    = 1'b1;
               state_d = StWait;
            end
         end
         StWait: begin
            if (bus.flush) begin
               // A same-cycle ack is simply dropped; otherwise drain the late ack in StFlush.
               rd_d    = 1'b0;
               state_d = bus.mem_ack ? StIdle : StFlush;
            end else if (bus.mem_ack) begin
               ir_d    = bus.mem_data;
               irv_d   = 1'b1;
               inc_d   = 1'b1;
               rd_d    = 1'b0;
               state_d = StIdle;
            end else if (timeout) begin
               rd_d    = 1'b0;
               state_d = StFlush;
            end
         end
         StFlush: begin
            if (bus.mem_ack) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      if (bus.flush) begin
         irv_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         addr_q  <= '0;
         rd_q    <= 1'b0;
         ir_q    <= '0;
         irv_q   <= 1'b0;
         inc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rd_q    <= rd_d;
         ir_q    <= ir_d;
         irv_q   <= irv_d;
         inc_q   <= inc_d;
      end
   end

   assign bus.mem_addr = addr_q;
   assign bus.mem_rd   = rd_q;
   assign bus.ir_out   = ir_q;
   assign bus.ir_valid = irv_q;
   assign bus.pc_inc   = inc_q;
   assign bus.busy     = (state_q != StIdle);
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: transaction-level model checked every cycle,
// plus hand-computed literal checks for each scenario.
module tb_instr_fetch_unit;
   localparam int MODEL_TIMEOUT = 15;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   instr_fetch_unit_if #(.ADDR_W(16), .DATA_W(16)) bus ();

   instr_fetch_unit #(.ADDR_W(16), .DATA_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a read is either outstanding-and-wanted (m_pending) or outstanding-and-dead
   // (m_draining); everything else is idle.
   bit          m_init = 1'b0;
   bit          m_pending = 1'b0;
   bit          m_draining = 1'b0;
   int          m_waited = 0;
   logic [15:0] e_addr = '0;
   logic        e_rd = 1'b0;
   logic [15:0] e_ir = '0;
   logic        e_valid = 1'b0;
   logic        e_inc = 1'b0;
   logic        e_err = 1'b0;

   always @(posedge clk) begin
      bit          pend, drain;
      int          waited;
      logic [15:0] addr, ir;
      logic        rd, valid, inc, err;
      pend = m_pending; drain = m_draining; waited = m_waited;
      addr = e_addr; rd = e_rd; ir = e_ir; err = e_err;
      inc   = 1'b0;
      valid = e_valid && !bus.ir_consume;
      if (rst) begin
         pend = 0; drain = 0; waited = 0;
         addr = '0; rd = 0; ir = '0; valid = 0; err = 0;
      end else begin
         if (pend) begin
            if (bus.flush) begin
               pend = 0; drain = !bus.mem_ack; rd = 0;
            end else if (bus.mem_ack) begin
               pend = 0; rd = 0; ir = bus.mem_data; valid = 1; inc = 1;
            end else begin
               waited++;
`ifdef FETCH_TIMEOUT_EN
               if (waited == MODEL_TIMEOUT) begin
                  pend = 0; drain = 1; rd = 0; err = 1;
               end
`endif
            end
         end else if (drain) begin
            if (bus.mem_ack) drain = 0;
         end else if (bus.fetch_req && (!e_valid || bus.ir_consume) && !bus.flush) begin
            pend = 1; waited = 0; addr = bus.pc_addr; rd = 1;
         end
         if (bus.flush) begin
            valid = 0; err = 0;
         end
      end
      m_init     <= 1'b1;
      m_pending  <= pend;
      m_draining <= drain;
      m_waited   <= waited;
      e_addr     <= addr;
      e_rd       <= rd;
      e_ir       <= ir;
      e_valid    <= valid;
      e_inc      <= inc;
      e_err      <= err;
   end

   always @(negedge clk) begin
      if (m_init) begin
         chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
         chk("mem_rd", 32'(bus.mem_rd), 32'(e_rd));
         chk("ir_out", 32'(bus.ir_out), 32'(e_ir));
         chk("ir_valid", 32'(bus.ir_valid), 32'(e_valid));
         chk("pc_inc", 32'(bus.pc_inc), 32'(e_inc));
         chk("busy", 32'(bus.busy), 32'(m_pending || m_draining));
         chk("fetch_err", 32'(bus.fetch_err), 32'(e_err));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      bus.pc_addr = 16'h0BAD; bus.fetch_req = 1'b1; bus.ir_consume = 1'b0;
      bus.flush = 1'b0; bus.mem_ack = 1'b0; bus.mem_data = 16'h0000;

      // Reset with fetch_req held high
      tick(2);
      chk("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_ir_valid", 32'(bus.ir_valid), 32'd0);
      rst = 1'b0; bus.fetch_req = 1'b0;
      tick(1);

      // Basic fetch, ack 3 cycles after request
      bus.pc_addr = 16'h0010; bus.fetch_req = 1'b1;
      tick(1);
      bus.fetch_req = 1'b0;
      chk("t2_mem_rd", 32'(bus.mem_rd), 32'd1);
      chk("t2_mem_addr", 32'(bus.mem_addr), 32'h0010);
      tick(2);
      bus.mem_ack = 1'b1; bus.mem_data = 16'hA5C3;
      tick(1);
      bus.mem_ack = 1'b0;
      chk("t2_ir_out", 32'(bus.ir_out), 32'hA5C3);
      chk("t2_ir_valid", 32'(bus.ir_valid), 32'd1);
      chk("t2_pc_inc", 32'(bus.pc_inc), 32'd1);
      tick(1);
      chk("t2_pc_inc_off", 32'(bus.pc_inc), 32'd0);

      // Held IR blocks fetch until consumed; load wins over consume
      bus.pc_addr = 16'h0020; bus.fetch_req = 1'b1;
      tick(1);
      chk("t3_blocked", 32'(bus.mem_rd), 32'd0);
      bus.ir_consume = 1'b1;
      tick(1);
      bus.fetch_req = 1'b0; bus.ir_consume = 1'b0;
      chk("t3_started", 32'(bus.mem_rd), 32'd1);
      chk("t3_consumed", 32'(bus.ir_valid), 32'd0);
      tick(1);
      bus.mem_ack = 1'b1; bus.mem_data = 16'h5A5A; bus.ir_consume = 1'b1;
      tick(1);
      bus.mem_ack = 1'b0; bus.ir_consume = 1'b0;
      chk("t3_load_wins", 32'(bus.ir_valid), 32'd1);

      // Flush in IDLE drops IR; flush in WAIT with late ack
      bus.flush = 1'b1;
      tick(1);
      bus.flush = 1'b0;
      chk("t4_idle_flush", 32'(bus.ir_valid), 32'd0);
      bus.pc_addr = 16'h0030; bus.fetch_req = 1'b1;
      tick(1);
      bus.fetch_req = 1'b0; bus.flush = 1'b1;
      tick(1);
      bus.flush = 1'b0;
      chk("t4_flush_rd", 32'(bus.mem_rd), 32'd0);
      chk("t4_flush_busy", 32'(bus.busy), 32'd1);
      tick(1);
      bus.mem_ack = 1'b1; bus.mem_data = 16'h1234; bus.fetch_req = 1'b1;
      tick(1);
      bus.mem_ack = 1'b0; bus.fetch_req = 1'b0;
      chk("t4_late_busy", 32'(bus.busy), 32'd0);
      chk("t4_late_valid", 32'(bus.ir_valid), 32'd0);
      chk("t4_late_rd", 32'(bus.mem_rd), 32'd0);
      // flush and ack together
      bus.pc_addr = 16'h0040; bus.fetch_req = 1'b1;
      tick(1);
      bus.fetch_req = 1'b0;
      tick(1);
      bus.flush = 1'b1; bus.mem_ack = 1'b1; bus.mem_data = 16'h1234;
      tick(1);
      bus.flush = 1'b0; bus.mem_ack = 1'b0;
      chk("t4_same_busy", 32'(bus.busy), 32'd0);
      chk("t4_same_valid", 32'(bus.ir_valid), 32'd0);
      chk("t4_same_inc", 32'(bus.pc_inc), 32'd0);

      // Top-of-memory address, then back-to-back fetch
      bus.pc_addr = 16'hFFFF; bus.fetch_req = 1'b1;
      tick(1);
      bus.fetch_req = 1'b0;
      chk("t5_mem_addr", 32'(bus.mem_addr), 32'hFFFF);
      bus.mem_ack = 1'b1; bus.mem_data = 16'h0F0F;
      tick(1);
      bus.mem_ack = 1'b0;
      chk("t5_ir_out", 32'(bus.ir_out), 32'h0F0F);
      chk("t5_pc_inc", 32'(bus.pc_inc), 32'd1);
      bus.pc_addr = 16'h0100; bus.fetch_req = 1'b1; bus.ir_consume = 1'b1;
      tick(1);
      bus.fetch_req = 1'b0; bus.ir_consume = 1'b0;
      chk("t5_b2b_rd", 32'(bus.mem_rd), 32'd1);
      chk("t5_b2b_addr", 32'(bus.mem_addr), 32'h0100);

      // Long wait: timeout abort, or normal completion without the timeout feature
      tick(14);
      chk("t6_still_rd", 32'(bus.mem_rd), 32'd1);
      tick(1);
`ifdef FETCH_TIMEOUT_EN
      chk("t6_abort_rd", 32'(bus.mem_rd), 32'd0);
      chk("t6_err", 32'(bus.fetch_err), 32'd1);
`else
      chk("t6_wait_rd", 32'(bus.mem_rd), 32'd1);
`endif
      tick(25);
      bus.mem_ack = 1'b1; bus.mem_data = 16'hBEEF;
      tick(1);
      bus.mem_ack = 1'b0;
      chk("t6_busy", 32'(bus.busy), 32'd0);
`ifdef FETCH_TIMEOUT_EN
      chk("t6_discard", 32'(bus.ir_valid), 32'd0);
      chk("t6_err_sticky", 32'(bus.fetch_err), 32'd1);
      bus.flush = 1'b1;
      tick(1);
      bus.flush = 1'b0;
      chk("t6_err_clr", 32'(bus.fetch_err), 32'd0);
`else
      chk("t6_ir_out", 32'(bus.ir_out), 32'hBEEF);
      chk("t6_pc_inc", 32'(bus.pc_inc), 32'd1);
      chk("t6_no_err", 32'(bus.fetch_err), 32'd0);
`endif

      // Reset in the middle of a fetch
      bus.pc_addr = 16'h0200; bus.fetch_req = 1'b1; bus.ir_consume = 1'b1;
      tick(1);
      bus.fetch_req = 1'b0; bus.ir_consume = 1'b0;
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("rst2_busy", 32'(bus.busy), 32'd0);
      chk("rst2_addr", 32'(bus.mem_addr), 32'h0000);
      chk("rst2_ir", 32'(bus.ir_out), 32'h0000);
      tick(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
